// File: rtl/u409_bus_initiator.sv
// u409_bus_initiator: single-beat MC68040 bus master.
// Arbitrates, runs one TS/TIP cycle, returns data or error.
module u409_bus_initiator #(
    parameter logic [6:0] TIMEOUT_CLKS = 7'd120
) (
    input  logic        CLK40,
    input  logic        RESETn,
    input  logic        REQ,
    input  logic        REQ_RWn,
    input  logic [1:0]  REQ_SIZ,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        REQ_DONE,
    output logic        REQ_ERR,
    output logic [31:0] REQ_RDATA,
    output logic        BRn,
    input  logic        BGn,
    input  logic        BBn_IN,
    output logic        BUS_OE,
    output logic [31:0] A,
    output logic [1:0]  SIZ,
    output logic [1:0]  TT,
    output logic        RWn,
    output logic [31:0] D_OUT,
    input  logic [31:0] D_IN,
    output logic        TSn,
    output logic        TIPn,
    output logic        BBn_OUT,
    input  logic        TACKn,
    input  logic        TEAn,
    input  logic        TBIn
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_START,
        S_WAIT,
        S_TERM,
        S_RELEASE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [6:0] wdog;
    logic       err_q;

    logic req_ok;
    logic bad_siz;
    logic grant;
    logic ack;
    logic tmo;
    logic wait_exit;

    // REQ_DONE blocks the clock after a completion so a held REQ is not re-taken.
    assign req_ok    = REQ && !REQ_DONE;
    assign bad_siz   = (REQ_SIZ == 2'b11);
    assign grant     = !BGn && BBn_IN;
    // TBIn only matters for bursts; single-beat cycles ignore it.
    assign ack       = !TEAn || !TACKn || (TBIn && 1'b0);
    assign tmo       = (wdog == TIMEOUT_CLKS);
    assign wait_exit = ack || tmo;
    assign TT        = 2'b00;

    // State register.
    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (req_ok && !bad_siz) begin
                    state_nx = S_ARB;
                end
            end
            S_ARB: begin
                if (!REQ) begin
                    state_nx = S_IDLE;
                end else if (grant) begin
                    state_nx = S_START;
                end
            end
            S_START:   state_nx = S_WAIT;
            S_WAIT: begin
                if (wait_exit) begin
                    state_nx = S_TERM;
                end
            end
            S_TERM:    state_nx = S_RELEASE;
            S_RELEASE: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Registered bus outputs, watchdog and requester status.
    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            BRn       <= 1'b1;
            BUS_OE    <= 1'b0;
            TSn       <= 1'b1;
            TIPn      <= 1'b1;
            BBn_OUT   <= 1'b1;
            RWn       <= 1'b1;
            A         <= '0;
            D_OUT     <= '0;
            SIZ       <= 2'b00;
            REQ_DONE  <= 1'b0;
            REQ_ERR   <= 1'b0;
            REQ_RDATA <= '0;
            wdog      <= '0;
            err_q     <= 1'b0;
        end else begin
            REQ_DONE <= 1'b0;
            REQ_ERR  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_ok && bad_siz) begin
                        REQ_DONE <= 1'b1;
                        REQ_ERR  <= 1'b1;
                    end else if (req_ok) begin
                        A     <= REQ_ADDR;
                        SIZ   <= REQ_SIZ;
                        RWn   <= REQ_RWn;
                        D_OUT <= REQ_WDATA;
                        BRn   <= 1'b0;
                    end
                end
                S_ARB: begin
                    if (!REQ) begin
                        BRn <= 1'b1;
                    end else if (grant) begin
                        BUS_OE  <= 1'b1;
                        BBn_OUT <= 1'b0;
                        TSn     <= 1'b0;
                        TIPn    <= 1'b0;
                        BRn     <= 1'b1;
                    end
                end
                S_START: begin
                    TSn  <= 1'b1;
                    wdog <= 7'd1;
                end
                S_WAIT: begin
                    if (wait_exit) begin
                        TIPn    <= 1'b1;
                        BBn_OUT <= 1'b1;
                        err_q   <= !TEAn || TACKn;
                        if (TEAn && !TACKn && RWn) begin
                            REQ_RDATA <= D_IN;
                        end
                    end else begin
                        wdog <= wdog + 7'd1;
                    end
                end
                S_TERM: begin
                    REQ_DONE <= 1'b1;
                    REQ_ERR  <= err_q;
                    wdog     <= '0;
                end
                S_RELEASE: begin
                    BUS_OE <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
